// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 framebuffer driver: FSM states, command
// sources, SSD1306 opcodes and the power-on init command ROM.
package oled_pkg;

  typedef enum logic [3:0] {
    POWER,
    LOAD_CMD,
    SEND,
    NEXT_CMD,
    WINDOW,
    FETCH,
    LOAD_DATA,
    NEXT_DATA,
    CONTRAST
  } state_t;

  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_WINDOW,
    SRC_CONTRAST
  } cmd_src_t;

  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_CONTRAST  = 8'h81;

  localparam int INIT_LEN     = 23;
  localparam int WINDOW_LEN   = 6;
  localparam int CONTRAST_LEN = 2;

  // Byte 10 is the multiplex ratio, which depends on the panel height.
  function automatic logic [7:0] init_byte(input logic [4:0] idx, input logic [7:0] mux_ratio);
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'h81;
      5'd2:    b = 8'h7F;
      5'd3:    b = 8'hA6;
      5'd4:    b = 8'h20;
      5'd5:    b = 8'h00;
      5'd6:    b = 8'hC8;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'hA1;
      5'd9:    b = 8'hA8;
      5'd10:   b = mux_ratio;
      5'd11:   b = 8'hD3;
      5'd12:   b = 8'h00;
      5'd13:   b = 8'hD5;
      5'd14:   b = 8'h80;
      5'd15:   b = 8'hD9;
      5'd16:   b = 8'h22;
      5'd17:   b = 8'hDB;
      5'd18:   b = 8'h20;
      5'd19:   b = 8'h8D;
      5'd20:   b = 8'h14;
      5'd21:   b = 8'hA4;
      5'd22:   b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_byte.sv
// MSB-first SPI byte serialiser (mode 3): SCLK idles high, data changes on the
// falling edge, and chip select frames each byte.
module oled_spi_byte
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdin,
  output logic       cs
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] shreg;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       high_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk       <= 1'b1;
      sdin       <= 1'b0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      shreg      <= 8'h00;
      div_cnt    <= 8'h00;
      bit_cnt    <= 3'd0;
      high_phase <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy       <= 1'b1;
          cs         <= 1'b0;
          sclk       <= 1'b0;
          sdin       <= data[7];
          shreg      <= {data[6:0], 1'b0};
          div_cnt    <= 8'h00;
          bit_cnt    <= 3'd0;
          high_phase <= 1'b0;
        end
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= 8'h00;
        if (!high_phase) begin
          sclk       <= 1'b1;
          high_phase <= 1'b1;
        end else if (bit_cnt == 3'd7) begin
          // SCLK stays high; releasing CS ends the byte.
          busy       <= 1'b0;
          cs         <= 1'b1;
          done       <= 1'b1;
          high_phase <= 1'b0;
        end else begin
          sclk       <= 1'b0;
          sdin       <= shreg[7];
          shreg      <= {shreg[6:0], 1'b0};
          bit_cnt    <= bit_cnt + 3'd1;
          high_phase <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 8'h01;
      end
    end
  end

endmodule

// File: rtl/oled_fb_driver.sv
// SSD1306 OLED driver: power/reset sequencing, init command stream, then a
// continuous framebuffer refresh with optional contrast updates between frames.
module oled_fb_driver
  import oled_pkg::*;
#(
  parameter int STARTUP_WAIT = 10000000,
  parameter int CLK_DIV      = 1,
  parameter int COLUMNS      = 128,
  parameter int PAGES        = 8,
  parameter int FB_AW        = $clog2(COLUMNS * PAGES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             io_sclk,
  output logic             io_sdin,
  output logic             io_cs,
  output logic             io_dc,
  output logic             io_reset,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_data,
  input  logic             contrast_valid,
  input  logic [7:0]       contrast,
  output logic             contrast_ready,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int PW = $clog2(3 * STARTUP_WAIT + 1);
  localparam logic [PW-1:0]    SW_1      = PW'(STARTUP_WAIT);
  localparam logic [PW-1:0]    SW_2      = PW'(2 * STARTUP_WAIT);
  localparam logic [PW-1:0]    PWR_LAST  = PW'(3 * STARTUP_WAIT - 1);
  localparam logic [FB_AW-1:0] FB_LAST   = FB_AW'(COLUMNS * PAGES - 1);
  localparam logic [7:0]       LAST_COL  = 8'(COLUMNS - 1);
  localparam logic [7:0]       LAST_PAGE = 8'(PAGES - 1);
  localparam logic [7:0]       MUX_RATIO = 8'(PAGES * 8 - 1);

  state_t        state;
  cmd_src_t      cmd_src;
  logic [4:0]    cmd_idx;
  logic [PW-1:0] pwr_cnt;
  logic [PW-1:0] pwr_nxt;
  logic [7:0]    contrast_reg;
  logic [7:0]    cmd_byte;
  logic          cmd_last;
  logic [7:0]    spi_data;
  logic          spi_start;
  logic          spi_busy;
  logic          spi_done;

  assign pwr_nxt = pwr_cnt + PW'(1);

  always_comb begin
    cmd_byte = 8'h00;
    cmd_last = 1'b0;
    case (cmd_src)
      SRC_INIT: begin
        cmd_byte = init_byte(cmd_idx, MUX_RATIO);
        cmd_last = (cmd_idx == 5'(INIT_LEN - 1));
      end
      SRC_WINDOW: begin
        case (cmd_idx)
          5'd0:    cmd_byte = OP_COL_ADDR;
          5'd2:    cmd_byte = LAST_COL;
          5'd3:    cmd_byte = OP_PAGE_ADDR;
          5'd5:    cmd_byte = LAST_PAGE;
          default: cmd_byte = 8'h00;
        endcase
        cmd_last = (cmd_idx == 5'(WINDOW_LEN - 1));
      end
      SRC_CONTRAST: begin
        cmd_byte = (cmd_idx == 5'd0) ? OP_CONTRAST : contrast_reg;
        cmd_last = (cmd_idx == 5'(CONTRAST_LEN - 1));
      end
      default: begin
        cmd_byte = 8'h00;
        cmd_last = 1'b1;
      end
    endcase
  end

  assign spi_start      = ((state == LOAD_CMD) || (state == LOAD_DATA)) && !spi_busy;
  assign spi_data       = (state == LOAD_DATA) ? fb_data : cmd_byte;
  // The handshake is only open for the one boundary cycle between frames.
  assign contrast_ready = (state == CONTRAST) && contrast_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= POWER;
      cmd_src      <= SRC_INIT;
      cmd_idx      <= 5'd0;
      pwr_cnt      <= '0;
      contrast_reg <= 8'h00;
      io_dc        <= 1'b1;
      io_reset     <= 1'b1;
      fb_addr      <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        POWER: begin
          if (pwr_cnt == PWR_LAST) begin
            pwr_cnt  <= '0;
            io_reset <= 1'b1;
            cmd_src  <= SRC_INIT;
            cmd_idx  <= 5'd0;
            state    <= LOAD_CMD;
          end else begin
            pwr_cnt  <= pwr_nxt;
            io_reset <= !((pwr_nxt >= SW_1) && (pwr_nxt < SW_2));
          end
        end
        LOAD_CMD: begin
          if (!spi_busy) begin
            io_dc <= 1'b0;
            state <= SEND;
          end
        end
        LOAD_DATA: begin
          if (!spi_busy) begin
            io_dc <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (spi_done) begin
            if (io_dc) begin
              frame_done <= (fb_addr == FB_LAST);
              state      <= NEXT_DATA;
            end else begin
              state <= NEXT_CMD;
            end
          end
        end
        NEXT_CMD: begin
          if (cmd_last) begin
            if (cmd_src == SRC_WINDOW) begin
              state <= FETCH;
            end else begin
              frame_start <= 1'b1;
              state       <= WINDOW;
            end
          end else begin
            cmd_idx <= cmd_idx + 5'd1;
            state   <= LOAD_CMD;
          end
        end
        WINDOW: begin
          cmd_src <= SRC_WINDOW;
          cmd_idx <= 5'd0;
          state   <= LOAD_CMD;
        end
        FETCH: begin
          state <= LOAD_DATA;
        end
        NEXT_DATA: begin
          if (fb_addr == FB_LAST) begin
            fb_addr <= '0;
            state   <= CONTRAST;
          end else begin
            fb_addr <= fb_addr + FB_AW'(1);
            state   <= FETCH;
          end
        end
        CONTRAST: begin
          if (contrast_valid) begin
            contrast_reg <= contrast;
            cmd_src      <= SRC_CONTRAST;
            cmd_idx      <= 5'd0;
            state        <= LOAD_CMD;
          end else begin
            frame_start <= 1'b1;
            state       <= WINDOW;
          end
        end
        default: state <= POWER;
      endcase
    end
  end

  oled_spi_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_spi (
    .clk  (clk),
    .rst  (rst),
    .start(spi_start),
    .data (spi_data),
    .busy (spi_busy),
    .done (spi_done),
    .sclk (io_sclk),
    .sdin (io_sdin),
    .cs   (io_cs)
  );

endmodule

// File: tb/tb_oled_fb_driver.sv
// Bench for oled_fb_driver: decodes the SPI stream and compares it with the
// command/frame sequence expected from a behavioural model of the panel traffic.
module tb_oled_fb_driver;

  localparam int SW      = 4;
  localparam int DIV     = 2;
  localparam int COLS    = 8;
  localparam int PG      = 2;
  localparam int NBYTES  = COLS * PG;
  localparam int AW      = $clog2(NBYTES);
  localparam int BUDGET  = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          io_sclk, io_sdin, io_cs, io_dc, io_reset;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data = 8'h00;
  logic          contrast_valid = 1'b0;
  logic [7:0]    contrast = 8'h00;
  logic          contrast_ready, frame_start, frame_done;

  int vectors = 0;
  int misses  = 0;

  logic [7:0] fb_mem [NBYTES];
  logic [8:0] rx_q [$];
  int         timing_err = 0;
  int         fs_count = 0, fd_count = 0, cr_count = 0;

  logic       in_byte = 1'b0;
  logic       lvl = 1'b1;
  logic       byte_dc = 1'b0;
  int         run = 0, nbits = 0;
  logic [7:0] sh = 8'h00;

  logic [7:0] init_exp [23];
  logic [7:0] rand_contrast;

  oled_fb_driver #(
    .STARTUP_WAIT(SW),
    .CLK_DIV     (DIV),
    .COLUMNS     (COLS),
    .PAGES       (PG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .io_sclk       (io_sclk),
    .io_sdin       (io_sdin),
    .io_cs         (io_cs),
    .io_dc         (io_dc),
    .io_reset      (io_reset),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .contrast_valid(contrast_valid),
    .contrast      (contrast),
    .contrast_ready(contrast_ready),
    .frame_start   (frame_start),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous-read framebuffer: data follows the address by one clock.
  always @(posedge clk) fb_data <= fb_mem[fb_addr];

  // SPI decoder: measures every SCLK phase and collects {dc, byte} per CS frame.
  always @(negedge clk) begin
    if (rst) begin
      in_byte = 1'b0;
    end else if (!io_cs) begin
      if (!in_byte) begin
        in_byte = 1'b1;
        nbits   = 0;
        sh      = 8'h00;
        run     = 1;
        lvl     = io_sclk;
        byte_dc = io_dc;
        if (io_sclk !== 1'b0) timing_err++;
      end else if (io_sclk == lvl) begin
        run++;
      end else begin
        if (run != DIV) timing_err++;
        if (io_sclk) begin
          sh = {sh[6:0], io_sdin};
          nbits++;
        end
        lvl = io_sclk;
        run = 1;
      end
      if (io_dc !== byte_dc) timing_err++;
    end else if (in_byte) begin
      if (run != DIV || lvl != 1'b1 || nbits != 8) timing_err++;
      rx_q.push_back({byte_dc, sh});
      in_byte = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_count++;
      if (frame_done) fd_count++;
      if (contrast_ready) cr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      misses++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] value);
    contrast_valid = valid;
    contrast       = value;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sclk"}, 32'(io_sclk), 32'd1);
    checkOutput({tag, "_sdin"}, 32'(io_sdin), 32'd0);
    checkOutput({tag, "_cs"}, 32'(io_cs), 32'd1);
    checkOutput({tag, "_dc"}, 32'(io_dc), 32'd1);
    checkOutput({tag, "_reset"}, 32'(io_reset), 32'd1);
    checkOutput({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    checkOutput({tag, "_pulses"}, {29'd0, contrast_ready, frame_start, frame_done}, 32'd0);
  endtask

  // Called at the falling edge right after the last reset edge.
  task automatic checkPowerSequence(input string tag);
    for (int k = 0; k < 3 * SW; k++) begin
      checkOutput($sformatf("%s_ioreset_%0d", tag, k), 32'(io_reset),
                  (k >= SW && k < 2 * SW) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic expectByte(input string tag, input logic dc, input logic [7:0] val);
    logic [8:0] got;
    int c;
    c = 0;
    while (rx_q.size() == 0 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_arrived"}, 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) begin
      got = rx_q.pop_front();
      checkOutput(tag, {23'd0, got}, {23'd0, dc, val});
    end
  endtask

  task automatic expectWindow(input string tag);
    expectByte({tag, "_w0"}, 1'b0, 8'h21);
    expectByte({tag, "_w1"}, 1'b0, 8'h00);
    expectByte({tag, "_w2"}, 1'b0, 8'(COLS - 1));
    expectByte({tag, "_w3"}, 1'b0, 8'h22);
    expectByte({tag, "_w4"}, 1'b0, 8'h00);
    expectByte({tag, "_w5"}, 1'b0, 8'(PG - 1));
  endtask

  task automatic expectData(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++)
      expectByte($sformatf("%s_d%0d", tag, i), 1'b1, fb_mem[i]);
  endtask

  task automatic waitFrameDone(input string tag, input int target);
    int c;
    c = 0;
    while (fd_count < target && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_frame_done"}, 32'(fd_count), 32'(target));
  endtask

  task automatic randomizeFrame();
    for (int i = 0; i < NBYTES; i++) fb_mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int rises;
    logic prev;
    init_exp = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'h40, 8'hA1, 8'hA8,
                 8'(PG * 8 - 1), 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9, 8'h22, 8'hDB,
                 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};
    for (int i = 0; i < NBYTES; i++) fb_mem[i] = 8'(i);
    applyStimulus(1'b0, 8'h00);

    // Power-on reset and the three-phase panel reset sequence.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst = 1'b0;
    checkPowerSequence("por");

    for (int i = 0; i < 23; i++)
      expectByte($sformatf("init_%0d", i), 1'b0, init_exp[i]);

    // Frame 1: identity framebuffer.
    expectWindow("f1");
    checkOutput("f1_frame_start", 32'(fs_count), 32'd1);
    expectData("f1", 0, NBYTES - 1);
    waitFrameDone("f1", 1);
    @(negedge clk);
    checkOutput("f1_addr_wrap", 32'(fb_addr), 32'd0);
    randomizeFrame();

    // Frame 2: contrast request raised mid-frame must not disturb the frame.
    expectWindow("f2");
    expectData("f2", 0, NBYTES / 2 - 1);
    applyStimulus(1'b1, 8'h3C);
    expectData("f2", NBYTES / 2, NBYTES - 1);
    checkOutput("f2_no_early_ready", 32'(cr_count), 32'd0);
    randomizeFrame();
    expectByte("f2_contrast_op", 1'b0, 8'h81);
    expectByte("f2_contrast_val", 1'b0, 8'h3C);
    checkOutput("f2_ready_once", 32'(cr_count), 32'd1);
    rand_contrast = 8'($urandom_range(0, 255));
    applyStimulus(1'b1, rand_contrast);

    // Frame 3: valid held across the frame is accepted once more at its end.
    expectWindow("f3");
    checkOutput("f3_ready_count", 32'(cr_count), 32'd1);
    expectData("f3", 0, NBYTES - 1);
    expectByte("f3_contrast_op", 1'b0, 8'h81);
    applyStimulus(1'b0, 8'h00);
    expectByte("f3_contrast_val", 1'b0, rand_contrast);
    checkOutput("f3_ready_count_end", 32'(cr_count), 32'd2);

    // Frame 4: no request, so the boundary goes straight to the window.
    expectWindow("f4");
    expectData("f4", 0, NBYTES - 1);
    expectWindow("f5");
    checkOutput("f5_ready_count", 32'(cr_count), 32'd2);
    checkOutput("f5_frame_done_count", 32'(fd_count), 32'd4);
    checkOutput("f5_frame_start_count", 32'(fs_count), 32'd5);
    expectData("f5", 0, 2);

    // Reset in the low phase of the fifth bit of the next data byte.
    rises = 0;
    prev  = io_sclk;
    for (int c = 0; c < BUDGET && !(rises == 4 && !io_sclk && !io_cs); c++) begin
      @(negedge clk);
      if (!io_cs && io_sclk && !prev) rises++;
      prev = io_sclk;
    end
    checkOutput("midbyte_bit5_reached", 32'(rises), 32'd4);
    checkOutput("midbyte_dc", 32'(io_dc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("midbyte");
    rx_q.delete();
    rst = 1'b0;
    checkPowerSequence("rerun");
    expectByte("rerun_init_0", 1'b0, 8'hAE);
    expectByte("rerun_init_1", 1'b0, 8'h81);

    checkOutput("spi_timing_errors", 32'(timing_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/oled_fb_driver.md
OLED_FB_DRIVER -- requirements
Module: oled_fb_driver

Interface
REQ-001 The block SHALL have parameter STARTUP_WAIT, default 10000000, giving the clk cycles per reset-sequence phase.
REQ-002 The block SHALL have parameter CLK_DIV, default 1, giving the clk cycles per SCLK half-period (legal range 1..255).
REQ-003 The block SHALL have parameter COLUMNS, default 128, giving the display width in segments.
REQ-004 The block SHALL have parameter PAGES, default 8, giving the display height in 8-row pages.
REQ-005 The block SHALL have parameter FB_AW, default $clog2(COLUMNS*PAGES), giving the framebuffer address width.
REQ-006 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Ports io_sclk, io_sdin, io_cs, io_dc, io_reset SHALL be outputs, 1 bit each: the SPI clock, data, chip select (low-active), data/command select (0=command), and panel reset (low-active).
REQ-009 Port fb_addr, output, FB_AW bits: the framebuffer read address, byte index = page*COLUMNS + column.
REQ-010 Port fb_data, input, 8 bits: the framebuffer byte, valid exactly one clk after fb_addr changes.
REQ-011 Ports contrast_valid (input, 1), contrast (input, 8), and contrast_ready (output, 1): the contrast-update handshake.
REQ-012 Ports frame_start and frame_done SHALL be outputs, 1 bit each: single-cycle pulses.

Function
REQ-013 The FSM states SHALL be POWER, LOAD_CMD, SEND, NEXT_CMD, WINDOW, FETCH, LOAD_DATA, NEXT_DATA, CONTRAST.
REQ-014 POWER SHALL drive io_reset high for STARTUP_WAIT cycles, low for STARTUP_WAIT cycles, then high for STARTUP_WAIT cycles, and then go to LOAD_CMD.
REQ-015 The init ROM SHALL hold 23 bytes: AE 81 7F A6 20 00 C8 40 A1 A8 (PAGES*8-1) D3 00 D5 80 D9 22 DB 20 8D 14 A4 AF, sent in order with io_dc=0.
REQ-016 SEND SHALL shift the byte out MSB-first: per bit, io_sclk goes low and io_sdin is updated on the same edge, then is held CLK_DIV cycles; io_sclk then goes high and is held CLK_DIV cycles.
REQ-017 io_cs SHALL be low from the cycle after LOAD_* until the last SCLK high phase completes, then high for at least one cycle between bytes.
REQ-018 After the init ROM is exhausted, and at the start of every frame, WINDOW SHALL send the commands 21 00 (COLUMNS-1) 22 00 (PAGES-1) with io_dc=0.
REQ-019 frame_start SHALL pulse in the cycle WINDOW is entered.
REQ-020 FETCH SHALL present fb_addr and wait one cycle; LOAD_DATA SHALL then capture fb_data and send it with io_dc=1.
REQ-021 fb_addr SHALL increment after each data byte and wrap from COLUMNS*PAGES-1 to 0.
REQ-022 On wrap, frame_done SHALL pulse and the next frame SHALL begin with WINDOW, refreshing continuously.
REQ-023 contrast_ready SHALL be high only in the single cycle at a frame boundary (after frame_done) when contrast_valid=1; the contrast byte SHALL be captured in that cycle.
REQ-024 A contrast transfer SHALL send 81 followed by the captured value (io_dc=0) before WINDOW.
REQ-025 A contrast_valid held across a frame SHALL be accepted exactly once per boundary.
REQ-026 contrast_valid asserted mid-frame SHALL NOT disturb the current frame.
REQ-027 Counters SHALL use widths sufficient for STARTUP_WAIT*3 and CLK_DIV without overflow.

Reset
REQ-028 rst=1 at any cycle, including mid-byte, SHALL force state=POWER, io_sclk=1, io_sdin=0, io_cs=1, io_dc=1, io_reset=1, fb_addr=0, contrast_ready=0, frame_start=0, frame_done=0, and all counters=0.
REQ-029 After rst is released, the full power sequence and init SHALL be re-run.

Structure
REQ-030 A shared package oled_pkg SHALL hold the FSM state encoding, the init command ROM constants, and the SSD1306 opcodes (21, 22, 81).
REQ-031 The block SHALL contain one sub-module, oled_spi_byte: a byte serialiser with start/busy/done, CLK_DIV-parameterised, owning io_sclk, io_sdin, and io_cs.

Verification (STARTUP_WAIT=4, CLK_DIV=2, COLUMNS=8, PAGES=2)
REQ-032 Release rst: io_reset SHALL read 1,0,1 for 4 cycles each, then the 23 init bytes SHALL be decoded with byte 11 = 0F.
REQ-033 Decoded SPI: each bit SHALL hold 2 clk low + 2 clk high, be MSB-first, and io_cs SHALL rise between bytes.
REQ-034 With the framebuffer model fb[i]=i: 21 00 07 22 00 01 SHALL be followed by data 00..0F, frame_done SHALL pulse after byte 0F, and fb_addr SHALL return to 0.
REQ-035 contrast_valid=1 with contrast=3C held from mid-frame: contrast_ready SHALL pulse once at the frame end, then 81 3C SHALL be sent, then 21.
REQ-036 rst pulsed during the 5th data bit: outputs SHALL be at reset values the next cycle, and the power sequence SHALL restart.
